// File: rtl/rv_wb_uart.sv
// rv_wb_uart: Wishbone classic slave UART. TX byte FIFO feeding an 8N1
// serializer with programmable baud divisor (bit period = DIV+1 clocks).
// Optional receive path (2-flop sync, RX FSM, single-entry holding register)
// is compiled in when the macro UART_RX_EN is defined.
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, waiting for FIFO data
//   TX_START | start bit (low) for DIV+1 clocks
//   TX_DATA  | 8 data bits LSB first, DIV+1 clocks each
//   TX_STOP  | stop bit (high); chains directly into next byte if available
// RX FSM (UART_RX_EN only)
//   RX_IDLE  | waiting for a low level on the synchronized line
//   RX_START | half-bit wait, abort if line went back high
//   RX_DATA  | 8 mid-bit samples
//   RX_STOP  | stop-bit sample, store byte or flag frame error
module rv_wb_uart #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_stb,
  input  logic        i_wb_cyc,
  output logic        o_wb_ack,
  output logic        o_tx,
  input  logic        i_rx,
  output logic        o_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic          ack_q;
  logic [31:0]   rdat_q, rdat_d;
  logic          bus_req, wr_en, rd_en;
  logic [1:0]    reg_idx;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [3:0]    cnt_lo;
  logic          tx_full, tx_empty, push_req, push, pop;
  tx_state_e     tx_state_q, tx_state_d;
  logic [15:0]   div_q, baud_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_idx_q;
  logic          bit_end, tx_busy;
  logic          overflow_q, irq_en_q, irq_q, ovf_set, ovf_clr;
  logic          rx_valid, rx_err, rx_ovf;
  logic [7:0]    rx_byte;
  logic          unused_bus;

  assign bus_req  = i_wb_stb & i_wb_cyc & ~ack_q;
  assign reg_idx  = i_wb_adr[3:2];
  assign wr_en    = bus_req & i_wb_we;
  assign rd_en    = bus_req & ~i_wb_we;
  assign tx_full  = (count_q == CW'(FIFO_DEPTH));
  assign tx_empty = (count_q == '0);
  assign cnt_lo   = 4'(count_q);
  // a pop in the same cycle frees a slot, so a push into a full FIFO is legal then
  assign push_req = wr_en & (reg_idx == 2'd0) & i_wb_sel[0];
  assign push     = push_req & (~tx_full | pop);
  assign bit_end  = (baud_q == 16'd0);
  assign tx_busy  = (tx_state_q != TX_IDLE);
  assign ovf_set  = (push_req & tx_full & ~pop) | rx_ovf;
  assign ovf_clr  = wr_en & (reg_idx == 2'd1) & i_wb_sel[0] & i_wb_dat[3];
  assign o_wb_ack = ack_q;
  assign o_wb_dat = rdat_q;
  assign o_irq    = irq_q;
  assign unused_bus = ^{i_wb_adr[31:4], i_wb_adr[1:0], i_wb_dat[31:17], i_wb_sel[3]};

  // Bus handshake: one wait state, ack is a single-cycle pulse with read data
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q  <= bus_req;
      rdat_q <= rd_en ? rdat_d : '0;
    end
  end

  // Register read mux
  always_comb begin
    rdat_d = '0;
    case (reg_idx)
      2'd0:    rdat_d = {24'd0, rx_byte};
      2'd1:    rdat_d = {20'd0, cnt_lo, 2'b00, rx_err, rx_valid, overflow_q,
                         tx_busy, tx_empty, tx_full};
      2'd2:    rdat_d = {16'd0, div_q};
      default: rdat_d = '0;
    endcase
  end

  // Control registers, sticky overflow (set wins over clear) and registered irq
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_q      <= DEFAULT_DIV;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_en && reg_idx == 2'd2) begin
        if (i_wb_sel[0]) div_q[7:0]  <= i_wb_dat[7:0];
        if (i_wb_sel[1]) div_q[15:8] <= i_wb_dat[15:8];
      end
      if (wr_en && reg_idx == 2'd1 && i_wb_sel[2]) irq_en_q <= i_wb_dat[16];
      if (ovf_set)      overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
      irq_q <= irq_en_q & ((tx_empty & ~tx_busy) | rx_valid);
    end
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= i_wb_dat[7:0];
  end

  // FIFO pointers (wrap naturally at the power-of-two depth) and occupancy
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // TX state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) tx_state_q <= TX_IDLE;
    else         tx_state_q <= tx_state_d;
  end

  // TX next-state logic
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (!tx_empty) tx_state_d = TX_START;
      TX_START: if (bit_end) tx_state_d = TX_DATA;
      TX_DATA:  if (bit_end && bit_idx_q == 3'd7) tx_state_d = TX_STOP;
      TX_STOP:  if (bit_end) tx_state_d = tx_empty ? TX_IDLE : TX_START;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // TX outputs: line level is decoded from state so reset forces it high at once
  always_comb begin
    o_tx = 1'b1;
    pop  = 1'b0;
    case (tx_state_q)
      TX_IDLE:  pop  = ~tx_empty;
      TX_START: o_tx = 1'b0;
      TX_DATA:  o_tx = shift_q[0];
      TX_STOP:  pop  = bit_end & ~tx_empty;
      default:  o_tx = 1'b1;
    endcase
  end

  // TX datapath: baud down-counter reloads from DIV at every bit boundary
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      baud_q    <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else if (pop) begin
      shift_q   <= fifo_mem[rd_ptr_q];
      baud_q    <= div_q;
      bit_idx_q <= '0;
    end else if (tx_busy) begin
      if (bit_end) begin
        baud_q <= div_q;
        if (tx_state_q == TX_DATA) begin
          shift_q   <= {1'b0, shift_q[7:1]};
          bit_idx_q <= bit_idx_q + 1'b1;
        end
      end else begin
        baud_q <= baud_q - 1'b1;
      end
    end
  end

`ifdef UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e   rx_state_q, rx_state_d;
  logic        rx_meta_q, rx_sync_q, rx_valid_q, rx_err_q, rx_end, rx_store;
  logic [15:0] rx_baud_q;
  logic [7:0]  rx_shift_q, rx_data_q;
  logic [2:0]  rx_idx_q;

  assign rx_end   = (rx_baud_q == 16'd0);
  assign rx_store = (rx_state_q == RX_STOP) & rx_end & rx_sync_q;
  assign rx_ovf   = rx_store & rx_valid_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign rx_byte  = rx_data_q;

  // RX line synchronizer
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) rx_state_q <= RX_IDLE;
    else         rx_state_q <= rx_state_d;
  end

  // RX next-state logic
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (!rx_sync_q) rx_state_d = RX_START;
      RX_START: if (rx_end) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_end && rx_idx_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_end) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // RX datapath, holding register and frame error; DATA read consumes the byte
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_baud_q  <= '0;
      rx_shift_q <= '0;
      rx_idx_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: rx_baud_q <= {1'b0, div_q[15:1]};
        RX_START: begin
          if (rx_end) begin
            rx_baud_q <= div_q;
            rx_idx_q  <= '0;
          end else begin
            rx_baud_q <= rx_baud_q - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_end) begin
            rx_baud_q  <= div_q;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_idx_q   <= rx_idx_q + 1'b1;
          end else begin
            rx_baud_q <= rx_baud_q - 1'b1;
          end
        end
        default: if (!rx_end) rx_baud_q <= rx_baud_q - 1'b1;
      endcase
      if (rx_store) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end else if (rd_en && reg_idx == 2'd0) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_state_q == RX_STOP && rx_end && !rx_sync_q) rx_err_q <= 1'b1;
    end
  end
`else
  logic unused_rx;
  assign unused_rx = i_rx;
  assign rx_valid  = 1'b0;
  assign rx_err    = 1'b0;
  assign rx_byte   = 8'd0;
  assign rx_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_rv_wb_uart.sv
// Bench for rv_wb_uart (default build). Expected serial waveforms are built
// from byte lists: start 0, 8 data bits LSB first, stop 1, each DIV+1 clocks.
module tb_rv_wb_uart;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, wdat, rdat;
  logic        we, stb, cyc, ack, tx, rx, irq;
  logic [3:0]  sel;

  rv_wb_uart dut (
    .i_clk(clk), .i_reset(rst), .i_wb_adr(adr), .i_wb_dat(wdat), .o_wb_dat(rdat),
    .i_wb_we(we), .i_wb_sel(sel), .i_wb_stb(stb), .i_wb_cyc(cyc), .o_wb_ack(ack),
    .o_tx(tx), .i_rx(rx), .o_irq(irq)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_n = 0;
  int   ack_cyc = 0;
  logic tx_log  [0:65535];
  logic irq_log [0:65535];
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(negedge clk) begin
    tx_log[cyc_n]  = tx;
    irq_log[cyc_n] = irq;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where ack is seen.
  task automatic wb(input logic w, input logic [1:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] r, output int waits);
    adr = {28'd0, a, 2'b00}; wdat = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
    waits = 0; r = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      waits++;
      if (ack) begin
        r = rdat;
        ack_cyc = cyc_n;
        break;
      end
    end
    check("wb_ack", {31'd0, ack}, 32'd1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r; int w;
    wb(1'b1, a, d, s, r, w);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] r);
    int w;
    wb(1'b0, a, 32'd0, 4'hf, r, w);
  endtask

  task automatic wait_until(input int c);
    while (cyc_n < c) @(negedge clk);
  endtask

  // Compare logged line against the ideal gapless 8N1 stream of exp_q.
  task automatic check_stream(input int start, input int div, input string tag);
    int t = start; int bad = 0; logic e; logic [7:0] by;
    foreach (exp_q[f]) begin
      by = exp_q[f];
      for (int b = 0; b < 10; b++) begin
        e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : by[b-1];
        for (int k = 0; k <= div; k++) begin
          if (tx_log[t] !== e) bad++;
          t++;
        end
      end
    end
    check({tag, "_pre"},  {31'd0, tx_log[start-1]}, 32'd1);
    check({tag, "_bits"}, bad, 32'd0);
    check({tag, "_post"}, {31'd0, tx_log[t]}, 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    int w, a, s, e, div, n;
    rst = 1'b1; adr = '0; wdat = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    wb(1'b0, 2'd1, 32'd0, 4'hf, r, w);
    check("status_reset", r, 32'h2);
    check("ack_latency", w, 32'd1);
    check("idle_tx", {31'd0, tx}, 32'd1);
    rd(2'd2, r); check("div_reset", r, 32'd433);
    rd(2'd3, r); check("reg3_read", r, 32'd0);
    rd(2'd0, r); check("data_read_norx", r, 32'd0);

    wr(2'd2, 32'h0001_1234, 4'hf); rd(2'd2, r); check("div_full", r, 32'h1234);
    wr(2'd2, 32'h0000_ABCD, 4'h2); rd(2'd2, r); check("div_lane1", r, 32'hAB34);
    wr(2'd2, 32'hFFFF_0055, 4'h1); rd(2'd2, r); check("div_lane0", r, 32'hAB55);
    wr(2'd3, 32'hFFFF_FFFF, 4'hf); rd(2'd2, r); check("reg3_ignored", r, 32'hAB55);

    // Single frame 0xA5 at DIV=3
    wr(2'd2, 32'd3, 4'hf);
    wr(2'd0, 32'h0000_00A5, 4'h1);
    s = ack_cyc + 1;
    exp_q.delete(); exp_q.push_back(8'hA5);
    wait_until(s + 12);
    rd(2'd1, r); check("status_busy", r, 32'h6);
    wait_until(s + 45);
    check_stream(s, 3, "frame_a5");
    rd(2'd1, r); check("status_after_a5", r, 32'h2);
    wr(2'd0, 32'h0000_0077, 4'h2);
    repeat (3) @(negedge clk);
    rd(2'd1, r); check("no_push_sel0", r, 32'h2);

    // Fill: 17 writes fit (one goes to the shifter), the 18th overflows
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(2'd0, {24'd0, b}, 4'h1);
      if (i == 0) s = ack_cyc + 1;
    end
    rd(2'd1, r); check("status_full", r, 32'h5);
    wr(2'd0, 32'h0000_00EE, 4'h1);
    rd(2'd1, r); check("status_overflow", r, 32'hD);
    wr(2'd1, 32'h0000_0008, 4'hf);
    rd(2'd1, r); check("overflow_cleared", r & 32'h8, 32'h0);
    wait_until(s + 17 * 40 + 4);
    check_stream(s, 3, "fill_stream");
    rd(2'd1, r); check("status_drained", r, 32'h2);

    // Interrupt on transmitter going idle
    wr(2'd1, 32'h0001_0000, 4'hf);
    repeat (2) @(negedge clk);
    check("irq_idle", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'd1, 4'hf);
    wr(2'd0, 32'h0000_003C, 4'h1);
    s = ack_cyc + 1;
    e = s + 20;
    exp_q.delete(); exp_q.push_back(8'h3C);
    wait_until(e + 4);
    check("irq_mid_frame", {31'd0, irq_log[s + 5]}, 32'd0);
    check("irq_edge", {30'd0, irq_log[e - 1], irq_log[e + 1]}, 32'd1);
    check_stream(s, 1, "irq_frame");
    wr(2'd1, 32'h0000_0000, 4'hf);
    repeat (2) @(negedge clk);
    check("irq_disabled", {31'd0, irq}, 32'd0);

    // Randomized bursts at random divisors; i_rx wiggled but ignored
    for (int it = 0; it < 8; it++) begin
      div = (it == 0) ? 0 : $urandom_range(1, 6);
      n = $urandom_range(1, 6);
      wr(2'd2, div, 4'hf);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        exp_q.push_back(b);
        rx = 1'($urandom);
        wr(2'd0, {24'd0, b}, 4'h1);
        if (i == 0) s = ack_cyc + 1;
      end
      wait_until(s + n * 10 * (div + 1) + 3);
      check_stream(s, div, $sformatf("rand%0d", it));
      rd(2'd1, r); check("rand_status", r, 32'h2);
      rd(2'd0, r); check("rand_data_read", r, 32'd0);
    end
    rx = 1'b1;

    // Asynchronous reset in the middle of a data bit
    wr(2'd2, 32'd7, 4'hf);
    wr(2'd0, 32'h0000_0000, 4'h1);
    s = ack_cyc + 1;
    wait_until(s + 12);
    check("pre_reset_tx_low", {31'd0, tx}, 32'd0);
    #2 rst = 1'b1;
    #1 check("reset_tx_immediate", {31'd0, tx}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    rd(2'd1, r); check("status_after_reset", r, 32'h2);
    rd(2'd2, r); check("div_after_reset", r, 32'd433);
    check("tx_after_reset", {31'd0, tx}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
